// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory read port of the prefetch queue.
// The fetcher drives enable/address; the memory returns read data.
interface fetch_prefetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic              IMena;
  logic [ADDR_W-1:0] IMaddra;
  logic [DATA_W-1:0] IMdouta;

  modport master (
    output IMena,
    output IMaddra,
    input  IMdouta
  );

  modport slave (
    input  IMena,
    input  IMaddra,
    output IMdouta
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Decoupled instruction prefetcher: sequential IM reads into a
// DEPTH-entry {inst, pc} queue with stall, redirect flush and halt.
module fetch_prefetch_queue #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 7,
  parameter int          DEPTH    = 4,
  parameter int          IM_LAT   = 1,
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int         CW       = $clog2(DEPTH) + 1,
  localparam int         PW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_prefetch_queue_if.master im,
  input  logic                   redirect,
  input  logic [31:0]            redirectPC,
  input  logic                   stall,
  input  logic                   halt,
  output logic [DATA_W-1:0]      inst_out,
  output logic [31:0]            pc_out,
  output logic                   valid_out,
  output logic [CW-1:0]          count
);

  localparam int SW = CW + 3;

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [IM_LAT-1:0] fl_v_q, fl_v_d;
  logic [31:0]       fl_pc_q [IM_LAT];
  logic [31:0]       fl_pc_d [IM_LAT];
  logic [DATA_W-1:0] q_inst_q [DEPTH];
  logic [31:0]       q_pc_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        inflight;
  logic [SW-1:0]     occ;
  logic              issue, push, pop;

  assign valid_out = (count_q != '0);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < IM_LAT; i++)
      inflight = inflight + 3'(fl_v_q[i]);
    // Pops in this cycle are not credited back.
    occ   = SW'(count_q) + SW'(inflight);
    issue = !rst && !redirect && !halt
            && (occ < SW'(DEPTH));
    push  = fl_v_q[IM_LAT-1] && !redirect;
    pop   = valid_out && !stall && !redirect;
  end

  always_comb begin
    fetch_pc_d = issue ? fetch_pc_q + 32'd4
                       : fetch_pc_q;
    fl_v_d[0]  = issue;
    fl_pc_d[0] = fetch_pc_q;
    for (int i = 1; i < IM_LAT; i++) begin
      fl_v_d[i]  = fl_v_q[i-1];
      fl_pc_d[i] = fl_pc_q[i-1];
    end
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (redirect) begin
      fetch_pc_d = redirectPC;
      fl_v_d     = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      fl_v_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fl_v_q     <= fl_v_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload storage needs no reset; validity lives in the flags.
  always_ff @(posedge clk) begin
    fl_pc_q <= fl_pc_d;
    if (push) begin
      q_inst_q[wr_ptr_q] <= im.IMdouta;
      q_pc_q[wr_ptr_q]   <= fl_pc_q[IM_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(push && !pop && count_q == CW'(DEPTH)));
  end

  assign im.IMena   = issue;
  assign im.IMaddra = fetch_pc_q[ADDR_W+1:2];
  assign inst_out   = valid_out ? q_inst_q[rd_ptr_q] : '0;
  assign pc_out     = valid_out ? q_pc_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench: cycle table on a DEPTH=4/IM_LAT=1 instance,
// plus throughput/wrap sequences on DEPTH=8/IM_LAT=3/RESET_PC=0x1FC.
module tb_fetch_prefetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect, stall, halt;
  logic [31:0] redirect_pc;

  logic [31:0] inst_a, pc_a;
  logic        val_a;
  logic [2:0]  cnt_a;
  logic [31:0] inst_b, pc_b;
  logic        val_b;
  logic [3:0]  cnt_b;

  fetch_prefetch_queue_if #(.DATA_W(32), .ADDR_W(7)) ia ();
  fetch_prefetch_queue_if #(.DATA_W(32), .ADDR_W(7)) ib ();

  fetch_prefetch_queue #(
    .DEPTH(4), .IM_LAT(1), .RESET_PC(32'h0)
  ) dut_a (
    .clk(clk), .rst(rst), .im(ia),
    .redirect(redirect), .redirectPC(redirect_pc),
    .stall(stall), .halt(halt),
    .inst_out(inst_a), .pc_out(pc_a),
    .valid_out(val_a), .count(cnt_a)
  );

  fetch_prefetch_queue #(
    .DEPTH(8), .IM_LAT(3), .RESET_PC(32'h1FC)
  ) dut_b (
    .clk(clk), .rst(rst), .im(ib),
    .redirect(redirect), .redirectPC(redirect_pc),
    .stall(stall), .halt(halt),
    .inst_out(inst_b), .pc_out(pc_b),
    .valid_out(val_b), .count(cnt_b)
  );

  function automatic logic [31:0] mem_word(logic [6:0] a);
    return 32'h1000_0000 + {25'd0, a};
  endfunction

  // Memory models: mem[i] = 0x1000_0000 + i, latency 1 and 3.
  logic [31:0] a_p0;
  logic [31:0] b_p [3];
  always @(posedge clk) begin
    a_p0   <= mem_word(ia.IMaddra);
    b_p[0] <= mem_word(ib.IMaddra);
    b_p[1] <= b_p[0];
    b_p[2] <= b_p[1];
  end
  assign ia.IMdouta = a_p0;
  assign ib.IMdouta = b_p[2];

  typedef struct {
    logic        rst, stall, halt, redir;
    logic [31:0] rpc;
    logic        e_val;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_ena;
    logic [6:0]  e_addr;
  } vec_t;

  vec_t tbl[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic add(bit r, bit s, bit h, bit d,
                     logic [31:0] rpc, bit v,
                     logic [31:0] pc, int c,
                     bit e, int a);
    vec_t t;
    t.rst = r; t.stall = s; t.halt = h; t.redir = d;
    t.rpc = rpc; t.e_val = v; t.e_pc = pc;
    t.e_cnt = 3'(c); t.e_ena = e; t.e_addr = 7'(a);
    tbl.push_back(t);
  endtask

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_inst(bit v,
                                           logic [31:0] pc);
    return v ? mem_word(pc[8:2]) : 32'h0;
  endfunction

  logic [31:0] epc;
  logic [6:0]  b_addr [3];

  initial begin
    rst = 1'b1; stall = 1'b0; halt = 1'b0;
    redirect = 1'b0; redirect_pc = '0;

    add(1,0,0,0,0,     0,32'h00,0,0,8'h00);
    add(0,0,0,0,0,     0,32'h00,0,1,8'h00);
    add(0,0,0,0,0,     0,32'h00,0,1,8'h01);
    add(0,0,0,0,0,     1,32'h00,1,1,8'h02);
    add(0,1,0,0,0,     1,32'h04,1,1,8'h03);
    add(0,1,0,0,0,     1,32'h04,2,1,8'h04);
    add(0,1,0,0,0,     1,32'h04,3,0,8'h00);
    for (int i = 0; i < 7; i++)
      add(0,1,0,0,0,   1,32'h04,4,0,8'h00);
    add(0,0,0,0,0,     1,32'h04,4,0,8'h00);
    add(0,0,0,0,0,     1,32'h08,3,1,8'h05);
    add(0,0,0,0,0,     1,32'h0C,2,1,8'h06);
    add(0,0,0,0,0,     1,32'h10,2,1,8'h07);
    add(0,1,0,0,0,     1,32'h14,2,1,8'h08);
    add(0,1,0,0,0,     1,32'h14,3,0,8'h00);
    add(0,1,0,0,0,     1,32'h14,4,0,8'h00);
    add(0,1,0,1,32'h40,1,32'h14,4,0,8'h00);
    add(0,0,0,0,0,     0,32'h00,0,1,8'h10);
    add(0,0,0,0,0,     0,32'h00,0,1,8'h11);
    add(0,0,0,0,0,     1,32'h40,1,1,8'h12);
    add(0,0,0,1,32'h80,1,32'h44,1,0,8'h00);
    add(0,0,0,0,0,     0,32'h00,0,1,8'h20);
    add(0,0,0,0,0,     0,32'h00,0,1,8'h21);
    add(0,0,0,0,0,     1,32'h80,1,1,8'h22);
    add(0,0,1,0,0,     1,32'h84,1,0,8'h00);
    add(0,0,1,0,0,     1,32'h88,1,0,8'h00);
    add(0,0,1,0,0,     0,32'h00,0,0,8'h00);
    add(0,0,0,0,0,     0,32'h00,0,1,8'h23);
    add(0,0,0,0,0,     0,32'h00,0,1,8'h24);
    add(0,0,0,0,0,     1,32'h8C,1,1,8'h25);
    add(1,0,0,0,0,     1,32'h90,1,0,8'h00);
    add(0,0,0,0,0,     0,32'h00,0,1,8'h00);
    add(0,0,0,0,0,     0,32'h00,0,1,8'h01);
    add(0,0,0,0,0,     1,32'h00,1,1,8'h02);

    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; stall = tbl[i].stall;
      halt = tbl[i].halt; redirect = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      #1;
      applied++;
      chk($sformatf("a%0d valid", i),
          {31'd0, val_a}, {31'd0, tbl[i].e_val});
      chk($sformatf("a%0d pc", i), pc_a, tbl[i].e_pc);
      chk($sformatf("a%0d inst", i), inst_a,
          exp_inst(tbl[i].e_val, tbl[i].e_pc));
      chk($sformatf("a%0d count", i),
          {29'd0, cnt_a}, {29'd0, tbl[i].e_cnt});
      chk($sformatf("a%0d ena", i),
          {31'd0, ia.IMena}, {31'd0, tbl[i].e_ena});
      if (tbl[i].e_ena)
        chk($sformatf("a%0d addr", i),
            {25'd0, ia.IMaddra}, {25'd0, tbl[i].e_addr});
    end

    // Instance B: address wrap, fill latency, sustained rate.
    b_addr[0] = 7'd127; b_addr[1] = 7'd0; b_addr[2] = 7'd1;
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; halt = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    epc = 32'h1FC;
    for (int k = 0; k < 54; k++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      applied++;
      if (k < 3) begin
        chk($sformatf("b%0d ena", k), {31'd0, ib.IMena}, 32'd1);
        chk($sformatf("b%0d addr", k),
            {25'd0, ib.IMaddra}, {25'd0, b_addr[k]});
      end
      if (k < 4) begin
        chk($sformatf("b%0d valid", k), {31'd0, val_b}, 32'd0);
      end else begin
        chk($sformatf("b%0d valid", k), {31'd0, val_b}, 32'd1);
        chk($sformatf("b%0d pc", k), pc_b, epc);
        chk($sformatf("b%0d inst", k), inst_b,
            mem_word(epc[8:2]));
        if (cnt_b > 4'd4) begin
          miscompares++;
          $display("FAIL b%0d count: got %0d want <=4", k, cnt_b);
        end
        epc = epc + 32'd4;
      end
    end

    // Mid-run reset pulse on B.
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      applied++;
      if (k == 0) begin
        chk("brst count", {28'd0, cnt_b}, 32'd0);
        chk("brst ena", {31'd0, ib.IMena}, 32'd1);
        chk("brst addr", {25'd0, ib.IMaddra}, 32'd127);
      end
      if (k < 4) begin
        chk($sformatf("brst%0d valid", k), {31'd0, val_b}, 32'd0);
      end else begin
        chk("brst pc", pc_b, 32'h1FC);
        chk("brst inst", inst_b, 32'h1000_007F);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
